// File: rtl/bit_write_arbiter.sv
// Round-robin arbiter that serialises single-bit writes into a shared register.
// A clear command runs a one-bit-per-cycle sweep that zeroes the whole register.
module bit_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*IDX_W-1:0] idx,
  input  logic [NREQ-1:0]       val,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] sweep_cnt_reg, sweep_cnt_next;

  logic [IDX_W-1:0] req_idx [NREQ];
  logic [NREQ-1:0]  eligible;
  logic             found;
  logic [PTR_W-1:0] win;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_idx
      assign req_idx[gi] = idx[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // Masking the requester granted last cycle stops a held request re-writing.
  assign eligible = req & ~gnt_reg;

  always_comb begin
    int k;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int o = 0; o < NREQ; o++) begin
      k = int'(rr_ptr_reg) + o;
      if (k >= NREQ) k = k - NREQ;
      if (!found && eligible[PTR_W'(k)]) begin
        found = 1'b1;
        win   = PTR_W'(k);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    gnt_next       = '0;
    rr_ptr_next    = rr_ptr_reg;
    sweep_cnt_next = sweep_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next     = SWEEP;
          sweep_cnt_next = '0;
        end else if (found) begin
          gnt_next[win] = 1'b1;
          // Out-of-range indices still consume a grant but leave q untouched.
          if (int'(req_idx[win]) < WIDTH)
            q_next[req_idx[win]] = val[win];
          rr_ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
      end
      SWEEP: begin
        q_next[sweep_cnt_reg] = 1'b0;
        if (sweep_cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next     = IDLE;
          sweep_cnt_next = '0;
        end else begin
          sweep_cnt_next = sweep_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      gnt_reg       <= '0;
      rr_ptr_reg    <= '0;
      sweep_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      gnt_reg       <= gnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      sweep_cnt_reg <= sweep_cnt_next;
    end
  end

  assign gnt  = gnt_reg;
  assign q    = q_reg;
  assign busy = (state_reg == SWEEP);

endmodule

// File: tb/tb_bit_write_arbiter.sv
// Directed bench for bit_write_arbiter (WIDTH=8, NREQ=3): writes, round-robin,
// clear sweep, sweep immunity to req/clr, and asynchronous reset mid-sweep.
module tb_bit_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = '0;
  logic [8:0] idx = '0;
  logic [2:0] val = '0;
  logic       clr = 1'b0;
  logic [2:0] gnt;
  logic [7:0] q;
  logic       busy;

  int passed = 0;
  int total  = 0;

  bit_write_arbiter #(.WIDTH(8), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .req(req), .idx(idx), .val(val),
    .clr(clr), .gnt(gnt), .q(q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    check({tag, "_q"}, q, 8'h00);
    check({tag, "_gnt"}, gnt, 3'b000);
    check({tag, "_busy"}, busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Sets all eight bits through requester 0, one grant every other cycle.
  task automatic fill_ones();
    for (int b = 0; b < 8; b++) begin
      req = 3'b001; idx[2:0] = 3'(b); val[0] = 1'b1;
      step();
      req = 3'b000;
      step();
    end
    check("fill_q", q, 8'hFF);
  endtask

  // Called just after the clr edge: bit k-1 clears on sweep edge k.
  task automatic sweep_run(input string tag, input logic [7:0] start);
    logic [7:0] exp_q;
    exp_q = start;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_q[k-1] = 1'b0;
      check($sformatf("%s_q%0d", tag, k), q, exp_q);
      check($sformatf("%s_busy%0d", tag, k), busy, (k < 8) ? 1'b1 : 1'b0);
      check($sformatf("%s_gnt%0d", tag, k), gnt, 3'b000);
    end
  endtask

  initial begin
    step();
    async_reset("reset");

    // Single write via requester 1, held for one extra cycle.
    req = 3'b010; idx[5:3] = 3'd5; val = 3'b010;
    step();
    check("single_q", q, 8'h20);
    check("single_gnt", gnt, 3'b010);
    step();
    check("held_gnt", gnt, 3'b000);
    check("held_q", q, 8'h20);
    req = 3'b000;
    step();
    $display("single write: q=%h", q);

    // Round-robin from a fresh pointer.
    async_reset("reset_rr");
    req = 3'b111; idx = {3'd2, 3'd1, 3'd0}; val = 3'b111;
    step(); check("rr1_gnt", gnt, 3'b001); check("rr1_q", q, 8'h01);
    step(); check("rr2_gnt", gnt, 3'b010); check("rr2_q", q, 8'h03);
    step(); check("rr3_gnt", gnt, 3'b100); check("rr3_q", q, 8'h07);
    step(); check("rr4_gnt", gnt, 3'b001); check("rr4_q", q, 8'h07);
    req = 3'b000;
    step(); check("rr_idle_gnt", gnt, 3'b000);
    $display("round-robin: q=%h", q);

    // clr and req at the same IDLE edge: clr wins, sweep clears bits 0..7.
    fill_ones();
    clr = 1'b1; req = 3'b001; idx[2:0] = 3'd3; val[0] = 1'b0;
    step();
    check("clr_gnt", gnt, 3'b000);
    check("clr_busy", busy, 1'b1);
    check("clr_q", q, 8'hFF);
    clr = 1'b0;
    sweep_run("sweep", 8'hFF);
    step();
    check("post_sweep_gnt", gnt, 3'b001);
    check("post_sweep_q", q, 8'h00);
    req = 3'b000;
    $display("clr vs req sweep: q=%h", q);

    // Requests and a clr pulse during the sweep are ignored.
    clr = 1'b1;
    step();
    check("sw2_busy", busy, 1'b1);
    check("sw2_gnt", gnt, 3'b000);
    clr = 1'b0; req = 3'b100; idx[8:6] = 3'd6; val[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      clr = (k == 3);
      step();
      check($sformatf("sw2_gnt%0d", k), gnt, 3'b000);
      check($sformatf("sw2_busy%0d", k), busy, (k < 8) ? 1'b1 : 1'b0);
    end
    clr = 1'b0;
    step();
    check("sw2_after_gnt", gnt, 3'b100);
    check("sw2_after_q", q, 8'h40);
    req = 3'b000;
    $display("sweep ignores req/clr: q=%h", q);

    // Reset three cycles into a sweep, then a full sweep restarts from bit 0.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sw3_busy", busy, 1'b1);
    step(); step(); step();
    check("sw3_mid_busy", busy, 1'b1);
    async_reset("reset_mid");
    step();
    check("sw3_idle_busy", busy, 1'b0);
    fill_ones();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sw4_busy", busy, 1'b1);
    sweep_run("sweep4", 8'hFF);
    $display("reset mid-sweep and restart: q=%h", q);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
